// File: rtl/hash_byte_feeder.sv
// Byte feeder for the byte-serial hash core: buffers {last, byte} entries in a FIFO
// and replays them one message at a time over start / F_dr / F_rtr / End_Of_File.
module hash_byte_feeder #(
    parameter int DEPTH = 16,
    parameter int LEN_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_byte,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             start,
    output logic [7:0]       Byte,
    output logic             F_dr,
    output logic             End_Of_File,
    input  logic             F_rtr,
    input  logic             H_ready,
    output logic [LEN_W-1:0] msg_len,
    output logic             len_valid,
    output logic             busy,
    output logic [1:0]       state_dbg
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        STREAM    = 2'd2,
        WAIT_HASH = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [8:0]       mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] msg_len_q, msg_len_d;
    logic             len_valid_q, len_valid_d;

    logic       push;
    logic       pop;
    logic       fifo_empty;
    logic [8:0] head;

    // Handshakes: an input byte moves on in_valid & in_ready; a byte moves to the core
    // on F_dr & F_rtr. Valid never waits on ready, and a stalled offer is held stable.
    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];
    assign in_ready   = (count_q != CW'(DEPTH));
    assign push       = in_valid & in_ready;

    assign start       = (state_q == START);
    assign F_dr        = (state_q == STREAM) && !fifo_empty;
    assign End_Of_File = F_dr & head[8];
    assign Byte        = fifo_empty ? 8'h00 : head[7:0];
    assign pop         = F_dr & F_rtr;

    assign msg_len   = msg_len_q;
    assign len_valid = len_valid_q;
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        msg_len_d   = msg_len_q;
        len_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = STREAM;
            end
            STREAM: begin
                if (pop) begin
                    // Saturate rather than wrap so an oversized message reports the maximum.
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + LEN_W'(1);
                    if (End_Of_File) begin
                        state_d = WAIT_HASH;
                    end
                end
            end
            WAIT_HASH: begin
                if (H_ready) begin
                    msg_len_d   = cnt_q;
                    len_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cnt_q       <= '0;
            msg_len_q   <= '0;
            len_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cnt_q       <= cnt_d;
            msg_len_q   <= msg_len_d;
            len_valid_q <= len_valid_d;
        end
    end

    // Storage needs no reset; the pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= {in_last, in_byte};
        end
    end

endmodule

// File: tb/tb_hash_byte_feeder.sv
// Self-checking bench for hash_byte_feeder: scoreboard of {last, byte} entries and
// message lengths, checked as the core side consumes them.
module tb_hash_byte_feeder;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_byte;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;
    logic        start;
    logic [7:0]  Byte;
    logic        F_dr;
    logic        End_Of_File;
    logic        F_rtr;
    logic        H_ready;
    logic [31:0] msg_len;
    logic        len_valid;
    logic        busy;
    logic [1:0]  state_dbg;

    hash_byte_feeder #(.DEPTH(16), .LEN_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_byte(in_byte), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .start(start), .Byte(Byte), .F_dr(F_dr), .End_Of_File(End_Of_File),
        .F_rtr(F_rtr), .H_ready(H_ready),
        .msg_len(msg_len), .len_valid(len_valid), .busy(busy), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_bad = 0;
    int          n_start = 0;
    int          n_len = 0;
    int          msg_cnt = 0;
    int          hready_delay = 4;
    logic        in_msg = 1'b0;
    logic        stalled_prev = 1'b0;
    logic [9:0]  prev_out = '0;
    logic [8:0]  exp_q[$];
    logic [31:0] len_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input logic l);
        int guard = 0;
        in_byte  = b;
        in_last  = l;
        in_valid = 1'b1;
        while (!in_ready && guard < 300) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!in_ready) begin
            check("push_timeout", in_ready, 1);
        end else begin
            @(posedge clk);
            exp_q.push_back({l, b});
            msg_cnt++;
            if (l) begin
                len_q.push_back(32'(msg_cnt));
                msg_cnt = 0;
            end
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_fdr();
        int guard = 0;
        while (!F_dr && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("fdr_timeout", F_dr, 1);
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((exp_q.size() != 0 || len_q.size() != 0 || busy) && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain_timeout", guard < 1000, 1);
    endtask

    // Core model: raise H_ready a few cycles after the last byte is taken.
    initial begin
        H_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && F_dr && F_rtr && End_Of_File) begin
                repeat (hready_delay) @(posedge clk);
                #1 H_ready = 1'b1;
                @(posedge clk);
                #1 H_ready = 1'b0;
            end
        end
    end

    // Monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            in_msg       = 1'b0;
            stalled_prev = 1'b0;
        end else begin
            if (F_dr && F_rtr) begin
                check("byte_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check("byte", {End_Of_File, Byte}, exp_q.pop_front());
                end
            end
            if (len_valid) begin
                n_len++;
                check("len_expected", len_q.size() != 0, 1);
                if (len_q.size() != 0) begin
                    check("msg_len", msg_len, len_q.pop_front());
                end
                in_msg = 1'b0;
            end
            if (start) begin
                n_start++;
                check("start_overlap", in_msg, 0);
                in_msg = 1'b1;
            end
            check("eof_without_fdr", End_Of_File & ~F_dr, 0);
            if (stalled_prev) begin
                check("stall_hold", {F_dr, End_Of_File, Byte}, prev_out);
            end
            stalled_prev = F_dr & ~F_rtr;
            prev_out     = {F_dr, End_Of_File, Byte};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $display("test done: total=%0d bad=%0d", n_checks, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with a pushing host: nothing may be stored.
        rst      = 1'b1;
        in_byte  = 8'hAA;
        in_last  = 1'b1;
        in_valid = 1'b1;
        F_rtr    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_fdr", F_dr, 0);
        check("rst_start", start, 0);
        check("rst_msg_len", msg_len, 0);
        check("rst_len_valid", len_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_nothing_stored", busy, 0);

        // Single message with entry-latency checks.
        push_byte(8'h61, 1'b0);
        check("lat_start_e1", start, 0);
        push_byte(8'h62, 1'b0);
        check("lat_start_e2", start, 1);
        check("lat_fdr_e2", F_dr, 0);
        push_byte(8'h63, 1'b1);
        check("lat_fdr_e3", F_dr, 1);
        check("lat_byte_e3", Byte, 8'h61);
        wait_idle();

        // Stall pattern 1,0,0,1 on a five-byte message.
        F_rtr = 1'b0;
        for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i), i == 4);
        wait_fdr();
        F_rtr = 1'b1;
        @(posedge clk); #1;
        F_rtr = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        F_rtr = 1'b1;
        wait_idle();

        // Fill to DEPTH while stalled, then stream with continuous push.
        F_rtr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push_byte(8'($urandom_range(0, 255)), 1'b0);
        end
        check("full_in_ready", in_ready, 0);
        check("full_fdr", F_dr, 1);
        F_rtr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_byte(8'($urandom_range(0, 255)), i == 3);
            check("stream_in_ready", in_ready, 1);
        end
        wait_idle();

        // Two queued messages, slow digest.
        hready_delay = 10;
        push_byte(8'hA0, 1'b0);
        push_byte(8'hA1, 1'b1);
        push_byte(8'hB0, 1'b1);
        wait_idle();
        hready_delay = 4;

        // Reset in STREAM after two of four bytes.
        F_rtr = 1'b0;
        for (int i = 0; i < 4; i++) push_byte(8'hC0 + 8'(i), i == 3);
        wait_fdr();
        F_rtr = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        len_q.delete();
        msg_cnt = 0;
        @(posedge clk); #1;
        check("midrst_fdr", F_dr, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_len_valid", len_valid, 0);
        check("midrst_msg_len", msg_len, 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_empty", busy, 0);
        push_byte(8'h77, 1'b1);
        wait_idle();

        repeat (3) @(posedge clk);
        #1;
        check("start_count", n_start, 7);
        check("len_count", n_len, 6);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
